// File: rtl/spi_slave_rx_if.sv
// SPI slave receiver bundle: serial pins from the SPI master plus the
// parallel word-side handshake toward the local consumer.
//   sclk, cs_n, mosi : serial inputs from the SPI master (asynchronous)
//   miso             : serial data back to the master, MSB first
//   tx_data          : word returned to the master, sampled at word start
//   rx_ack           : consumer acknowledge of the current rx_data
//   rx_data          : last complete received word
//   rx_valid         : one-clock pulse when rx_data updates
//   rx_overrun       : one-clock pulse, word completed while previous unacked
//   frame_err        : one-clock pulse, cs_n deasserted mid-word
//   busy             : high while a frame is being shifted
// modport slave is the receiver block; modport master is its environment.
interface spi_slave_rx_if #(
    parameter int WIDTH = 8
);
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] tx_data;
    logic             rx_ack;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_overrun;
    logic             frame_err;
    logic             busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, rx_ack,
        output miso, rx_data, rx_valid, rx_overrun, frame_err, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, rx_ack,
        input  miso, rx_data, rx_valid, rx_overrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver/transmitter, oversampled by the system clock.
// The serial pins are synchronized into the clock domain and edge-detected;
// words of WIDTH bits are shifted in MSB first and handed to the consumer
// with a valid/ack handshake, while tx_data is shifted out on miso.
// Ports:
//   clock : system clock, rising edge (must run >= 8x sclk)
//   reset : synchronous, active-high
//   bus   : spi_slave_rx_if.slave (serial pins + word handshake)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cs_n high (or not yet freshly asserted); miso held 0
// SHIFT | frame active; sclk rises sample mosi, sclk falls advance miso
module spi_slave_rx #(
    parameter int WIDTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    spi_slave_rx_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic { IDLE = 1'b0, SHIFT = 1'b1 } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-2:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_data_r;
    logic             rx_valid_r;
    logic             rx_overrun_r;
    logic             frame_err_r;
    logic             busy_r;
    logic             miso_r;
    logic             rx_pending;
    logic             reload_pending;

    logic sclk_meta, sclk_sync, sclk_prev;
    logic cs_meta, cs_sync, cs_prev;
    logic mosi_meta, mosi_sync;
    logic [1:0] sync_ready;
    logic       cs_armed;

    logic             sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [WIDTH-1:0] rx_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_meta  <= 1'b0;
            sclk_sync  <= 1'b0;
            sclk_prev  <= 1'b0;
            cs_meta    <= 1'b1;
            cs_sync    <= 1'b1;
            cs_prev    <= 1'b1;
            mosi_meta  <= 1'b0;
            mosi_sync  <= 1'b0;
            sync_ready <= 2'b00;
            cs_armed   <= 1'b0;
        end else begin
            sclk_meta  <= bus.sclk;
            sclk_sync  <= sclk_meta;
            sclk_prev  <= sclk_sync;
            cs_meta    <= bus.cs_n;
            cs_sync    <= cs_meta;
            cs_prev    <= cs_sync;
            mosi_meta  <= bus.mosi;
            mosi_sync  <= mosi_meta;
            sync_ready <= {sync_ready[0], 1'b1};
            // The cs_n chain resets to 1, so a chip select held low through
            // reset would look like a falling edge. Only accept a falling
            // edge once cs_n has genuinely been seen high after the chain
            // has flushed its reset value.
            if (sync_ready[1] && cs_sync)
                cs_armed <= 1'b1;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;
    assign cs_fall   = cs_prev & ~cs_sync & cs_armed;
    assign cs_rise   = cs_sync & ~cs_prev;
    assign rx_next   = {rx_shift, mosi_sync};

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            rx_data_r      <= '0;
            rx_valid_r     <= 1'b0;
            rx_overrun_r   <= 1'b0;
            frame_err_r    <= 1'b0;
            busy_r         <= 1'b0;
            miso_r         <= 1'b0;
            rx_pending     <= 1'b0;
            reload_pending <= 1'b0;
        end else begin
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
            frame_err_r  <= 1'b0;
            // A completing word later in this block overrides the clear,
            // so a coincident ack leaves the new word pending.
            if (bus.rx_ack)
                rx_pending <= 1'b0;

            case (state)
                IDLE: begin
                    busy_r         <= 1'b0;
                    miso_r         <= 1'b0;
                    reload_pending <= 1'b0;
                    if (cs_fall) begin
                        state    <= SHIFT;
                        busy_r   <= 1'b1;
                        bit_cnt  <= '0;
                        tx_shift <= bus.tx_data;
                        miso_r   <= bus.tx_data[WIDTH-1];
                    end
                end

                SHIFT: begin
                    if (cs_rise) begin
                        // Partial word is dropped; rx_data stays as it was.
                        state          <= IDLE;
                        busy_r         <= 1'b0;
                        miso_r         <= 1'b0;
                        reload_pending <= 1'b0;
                        frame_err_r    <= (bit_cnt != '0);
                        bit_cnt        <= '0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next[WIDTH-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            rx_data_r      <= rx_next;
                            rx_valid_r     <= 1'b1;
                            rx_overrun_r   <= rx_pending & ~bus.rx_ack;
                            rx_pending     <= 1'b1;
                            bit_cnt        <= '0;
                            tx_shift       <= bus.tx_data;
                            reload_pending <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        // After a reload the MSB is already in tx_shift[WIDTH-1]
                        // and is presented without shifting.
                        if (reload_pending) begin
                            miso_r <= tx_shift[WIDTH-1];
                        end else begin
                            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                            miso_r   <= tx_shift[WIDTH-2];
                        end
                        reload_pending <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miso       = miso_r;
    assign bus.rx_data    = rx_data_r;
    assign bus.rx_valid   = rx_valid_r;
    assign bus.rx_overrun = rx_overrun_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: an SPI master model drives frames at
// clock/8, expected word-side events are queued when a frame is issued, and a
// monitor pops and compares them whenever the DUT pulses an output.
module tb_spi_slave_rx;
    localparam int W    = 8;
    localparam int HALF = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    spi_slave_rx_if #(.WIDTH(W)) bus ();

    spi_slave_rx #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           is_ferr;
        logic [W-1:0] data;
        bit           ovr;
    } exp_t;

    exp_t         expq[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           ack_mode = 0;   // 0: never ack, 1: ack pulse on valid, 2: ack held
    bit           model_pending = 1'b0;
    logic [W-1:0] model_last = '0;
    logic [W-1:0] fw[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor / consumer: owns rx_ack, checks every output pulse.
    initial begin
        exp_t e;
        bus.rx_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.rx_valid || bus.frame_err || bus.rx_overrun) begin
                if (expq.size() == 0) begin
                    check("unexpected_event", {29'd0, bus.rx_valid, bus.frame_err, bus.rx_overrun}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    if (e.is_ferr) begin
                        check("ferr_flag", bus.frame_err, 1);
                        check("ferr_no_valid", bus.rx_valid, 0);
                        check("ferr_rx_data_kept", bus.rx_data, e.data);
                    end else begin
                        check("valid_flag", bus.rx_valid, 1);
                        check("rx_data", bus.rx_data, e.data);
                        check("rx_overrun", bus.rx_overrun, e.ovr);
                    end
                end
            end
            if (ack_mode == 2)      bus.rx_ack = 1'b1;
            else if (ack_mode == 1) bus.rx_ack = bus.rx_valid;
            else                    bus.rx_ack = 1'b0;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        model_pending = 1'b0;
        model_last    = '0;
        tick(4);
    endtask

    // Reference: a frame of nbits bits carries nbits/W whole words; each one
    // overruns iff the previous word is still unacknowledged; a remainder
    // produces a frame error with rx_data left at the last whole word.
    task automatic send_frame(input int nbits, input logic [W-1:0] tx, input int mode);
        exp_t         e;
        logic [W-1:0] rcv = '0;
        ack_mode    = mode;
        bus.tx_data = tx;
        if (mode == 2) model_pending = 1'b0;
        for (int k = 0; k < nbits / W; k++) begin
            e.is_ferr = 1'b0;
            e.data    = fw[k];
            e.ovr     = model_pending;
            expq.push_back(e);
            model_pending = (mode == 0);
            model_last    = fw[k];
        end
        if (nbits % W != 0) begin
            e.is_ferr = 1'b1;
            e.data    = model_last;
            e.ovr     = 1'b0;
            expq.push_back(e);
        end
        tick(HALF);
        bus.cs_n = 1'b0;
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = fw[i / W][W - 1 - (i % W)];
            tick(HALF);
            rcv = {rcv[W-2:0], bus.miso};
            bus.sclk = 1'b1;
            if (i == 0) check("busy_in_frame", bus.busy, 1);
            if (i % W == W - 1) check("miso_word", rcv, tx);
            tick(HALF);
            bus.sclk = 1'b0;
        end
        tick(HALF);
        bus.cs_n = 1'b1;
        tick(6);
        check("busy_after_frame", bus.busy, 0);
        check("miso_idle", bus.miso, 0);
        tick(4);
    endtask

    initial begin
        int nw, nb;
        bus.sclk    = 1'b0;
        bus.cs_n    = 1'b1;
        bus.mosi    = 1'b0;
        bus.tx_data = '0;

        do_reset();
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_overrun", bus.rx_overrun, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_miso", bus.miso, 0);

        // Single word 0xA5 in, 0x3C out.
        fw[0] = 8'hA5;
        send_frame(8, 8'h3C, 1);

        // Back-to-back words, acknowledged, then unacknowledged.
        fw[0] = 8'h01;
        fw[1] = 8'hFE;
        send_frame(16, 8'h96, 1);
        send_frame(16, 8'h69, 0);

        // Frame aborted after 5 bits.
        fw[0] = 8'h5B;
        send_frame(5, 8'h11, 0);

        // Reset in the middle of a word, cs_n held low across reset.
        ack_mode    = 1;
        bus.tx_data = 8'h77;
        bus.cs_n    = 1'b0;
        tick(HALF);
        for (int i = 0; i < 3; i++) begin
            bus.mosi = i[0];
            tick(HALF);
            bus.sclk = 1'b1;
            tick(HALF);
            bus.sclk = 1'b0;
        end
        do_reset();
        tick(8);
        check("no_start_without_fresh_cs", bus.busy, 0);
        bus.cs_n = 1'b1;
        tick(8);
        fw[0] = 8'h5A;
        send_frame(8, 8'hC3, 1);

        // sclk activity with cs_n high is ignored.
        for (int i = 0; i < 6; i++) begin
            bus.mosi = i[0];
            bus.sclk = 1'b1;
            tick(HALF);
            bus.sclk = 1'b0;
            tick(HALF);
            check("idle_sclk_miso", bus.miso, 0);
            check("idle_sclk_busy", bus.busy, 0);
        end
        fw[0] = 8'h81;
        send_frame(8, 8'h42, 1);

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            nw = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) fw[k] = W'($urandom);
            nb = nw * W;
            if ($urandom_range(0, 3) == 0) nb = nb - W + $urandom_range(1, W - 1);
            send_frame(nb, W'($urandom), $urandom_range(0, 2));
        end

        for (int t = 0; t < 100 && expq.size() != 0; t++) tick(1);
        check("scoreboard_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
